hdmi_packet_scheduler: RTL and testbench

Schedules HDMI data islands inside horizontal/vertical blanking and arbitrates packet requests from up to `NUM_SOURCES` packet generators (audio sample, audio clock regeneration, InfoFrames). It sequences control, preamble, leading guard band, 32-cycle packet slots and trailing guard band. It presents one latched packet at a time to the downstream packet ECC/assembly stage, driving its `data_island_period`, `header` and `sub_0..sub_3` inputs. It also drives a period-mode code to the TMDS channel encoders.

---
 rtl/hdmi_packet_scheduler_if.sv | 25 ++
 rtl/hdmi_packet_scheduler.sv | 123 ++++++++++++
 tb/tb_hdmi_packet_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_packet_scheduler_if.sv
// Packet-source requests, blanking budget and latched-packet outputs of the data-island scheduler.
// master = scheduler side, slave = sources / downstream ECC stage.
interface hdmi_packet_scheduler_if #(
    parameter int NUM_SOURCES = 4
) ();
    logic [11:0]                blank_remaining;
    logic [NUM_SOURCES-1:0]     src_req;
    logic [NUM_SOURCES*24-1:0]  src_header;
    logic [NUM_SOURCES*224-1:0] src_sub;
    logic [NUM_SOURCES-1:0]     src_ack;
    logic [2:0]                 mode;
    logic                       data_island_period;
    logic [23:0]                header;
    logic [55:0]                sub_0, sub_1, sub_2, sub_3;
    logic                       overrun;

    modport master (
        input  blank_remaining, src_req, src_header, src_sub,
        output src_ack, mode, data_island_period, header, sub_0, sub_1, sub_2, sub_3, overrun
    );
    modport slave (
        output blank_remaining, src_req, src_header, src_sub,
        input  src_ack, mode, data_island_period, header, sub_0, sub_1, sub_2, sub_3, overrun
    );
endinterface

// File: rtl/hdmi_packet_scheduler.sv
// HDMI data-island sequencer: preamble, guard bands, 32-cycle packet slots and
// round-robin packet arbitration across NUM_SOURCES generators.
module hdmi_packet_scheduler #(
    parameter int NUM_SOURCES = 4,
    parameter int MAX_PACKETS = 18,
    parameter int MARGIN      = 4,
    parameter int COOLDOWN    = 4
) (
    input  logic clk_pixel,
    input  logic reset_n,
    hdmi_packet_scheduler_if.master bus
);
    localparam int          PTR_W     = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam logic [11:0] START_MIN = 12'(45 + MARGIN);
    localparam logic [11:0] CONT_MIN  = 12'(35 + MARGIN);
    localparam logic [4:0]  MAX_PKT   = 5'(MAX_PACKETS);
    localparam logic [4:0]  CD_LAST   = 5'(COOLDOWN - 1);

    // Encodings of the island states double as the mode code; COOLDOWN maps to 0.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_LEAD_GB  = 3'd2,
        S_PACKET   = 3'd3,
        S_TRAIL_GB = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [4:0]       phase, phase_n, pkt_cnt;
    logic [PTR_W-1:0] rr_ptr, grant_idx;
    logic             grant_found, abort, cont, latch;
    logic [2:0]       mode_r;
    logic             dip_r, overrun_r;
    logic [23:0]      header_r;
    logic [223:0]     sub_r;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int c;
        c = int'(p) + k;
        if (c >= NUM_SOURCES) c = c - NUM_SOURCES;
        return PTR_W'(c);
    endfunction

    // Scan downward so the nearest requester at or after rr_ptr is the last one written.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            if (bus.src_req[wrap_add(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    assign abort = (state != S_IDLE) && (state != S_COOLDOWN) && (bus.blank_remaining == 12'd0);
    assign cont  = (|bus.src_req) && (pkt_cnt < MAX_PKT) && (bus.blank_remaining >= CONT_MIN);
    assign latch = !abort && (((state == S_LEAD_GB) && (phase == 5'd1)) ||
                              ((state == S_PACKET) && (phase == 5'd31) && cont));

    always_comb begin
        state_n = state;
        phase_n = phase + 5'd1;
        case (state)
            S_IDLE: begin
                phase_n = '0;
                if ((|bus.src_req) && (bus.blank_remaining >= START_MIN)) state_n = S_PREAMBLE;
            end
            S_PREAMBLE: if (phase == 5'd7) begin state_n = S_LEAD_GB; phase_n = '0; end
            S_LEAD_GB:  if (phase == 5'd1) begin state_n = S_PACKET; phase_n = '0; end
            S_PACKET:   if ((phase == 5'd31) && !cont) begin state_n = S_TRAIL_GB; phase_n = '0; end
            S_TRAIL_GB: if (phase == 5'd1) begin state_n = S_COOLDOWN; phase_n = '0; end
            S_COOLDOWN: if (phase == CD_LAST) begin state_n = S_IDLE; phase_n = '0; end
            default: begin state_n = S_IDLE; phase_n = '0; end
        endcase
        if (abort) begin
            state_n = S_IDLE;
            phase_n = '0;
        end
    end

    // Ack is decoded from the current request so it coincides with the capture edge
    // and can be withheld in an aborting cycle.
    assign bus.src_ack = (latch && grant_found) ? (NUM_SOURCES'(1) << grant_idx) : '0;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            phase     <= '0;
            pkt_cnt   <= '0;
            rr_ptr    <= '0;
            mode_r    <= '0;
            dip_r     <= 1'b0;
            overrun_r <= 1'b0;
            header_r  <= '0;
            sub_r     <= '0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            mode_r    <= (state_n == S_COOLDOWN) ? 3'd0 : 3'(state_n);
            dip_r     <= (state_n == S_PACKET);
            overrun_r <= abort;
            if (latch) begin
                header_r <= grant_found ? bus.src_header[int'(grant_idx)*24 +: 24] : '0;
                sub_r    <= grant_found ? bus.src_sub[int'(grant_idx)*224 +: 224] : '0;
                if (grant_found) rr_ptr <= wrap_add(grant_idx, 1);
                pkt_cnt  <= (state == S_LEAD_GB) ? 5'd1 : pkt_cnt + 5'd1;
            end else if (state == S_IDLE) begin
                pkt_cnt <= '0;
            end
        end
    end

    assign bus.mode               = mode_r;
    assign bus.data_island_period = dip_r;
    assign bus.overrun            = overrun_r;
    assign bus.header             = header_r;
    assign bus.sub_0              = sub_r[55:0];
    assign bus.sub_1              = sub_r[111:56];
    assign bus.sub_2              = sub_r[167:112];
    assign bus.sub_3              = sub_r[223:168];
endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Self-checking bench: cycle-offset island model plus per-scenario checks.
module tb_hdmi_packet_scheduler;
    localparam int N      = 4;
    localparam int MAXP   = 18;
    localparam int MARGIN = 4;
    localparam int CD     = 4;

    logic clk_pixel = 1'b0;
    logic reset_n   = 1'b0;

    hdmi_packet_scheduler_if #(.NUM_SOURCES(N)) bus ();

    hdmi_packet_scheduler #(
        .NUM_SOURCES(N), .MAX_PACKETS(MAXP), .MARGIN(MARGIN), .COOLDOWN(CD)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // source-side stimulus
    int           want [N];
    logic [23:0]  cur_hdr [N];
    logic [223:0] cur_sub [N];
    logic [N-1:0] pop;
    int           blank_val;
    bit           blank_dec, rnd_arrive;

    // reference model: island described as offsets from its first preamble cycle
    bit           m_busy, m_ovr;
    int           m_rel, m_n, m_rr;
    logic [23:0]  m_hdr;
    logic [223:0] m_sub;

    logic [256:0] obs_v, exp_v;
    logic [N-1:0] obs_ack;
    logic [2:0]   obs_mode;
    logic         obs_dip, obs_ovr;

    task automatic new_packet(input int i);
        cur_hdr[i] = 24'($urandom);
        cur_sub[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.src_req[i]              = (want[i] > 0);
            bus.src_header[i*24 +: 24]  = cur_hdr[i];
            bus.src_sub[i*224 +: 224]   = cur_sub[i];
        end
        bus.blank_remaining = 12'(blank_val);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            want[i] = 0;
            new_packet(i);
        end
        pop = '0;
        blank_val = 0;
        blank_dec = 1'b0;
        rnd_arrive = 1'b0;
        drive();
        repeat (2) @(negedge clk_pixel);
        m_busy = 1'b0; m_ovr = 1'b0; m_rel = 0; m_n = 0; m_rr = 0;
        m_hdr = '0; m_sub = '0;
        reset_n = 1'b1;
    endtask

    // One clock: apply stimulus, snapshot DUT and model expectations, advance the model.
    task automatic tick();
        logic [N-1:0] req, e_ack;
        logic [2:0]   e_mode;
        int           blank, win;
        bit           abort, do_latch;
        @(negedge clk_pixel);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) begin
                if (want[i] > 0) want[i]--;
                new_packet(i);
            end
            if (rnd_arrive && $urandom_range(0, 23) == 0) want[i] += int'($urandom_range(1, 3));
        end
        pop = '0;
        drive();
        #1;
        for (int i = 0; i < N; i++) req[i] = (want[i] > 0);
        blank = blank_val;
        obs_mode = bus.mode;
        obs_dip  = bus.data_island_period;
        obs_ovr  = bus.overrun;
        obs_ack  = bus.src_ack;
        obs_v = {bus.mode, bus.data_island_period, bus.overrun, bus.src_ack, bus.header,
                 bus.sub_3, bus.sub_2, bus.sub_1, bus.sub_0};

        if (!m_busy)                   e_mode = 3'd0;
        else if (m_rel < 8)            e_mode = 3'd1;
        else if (m_rel < 10)           e_mode = 3'd2;
        else if (m_rel < 10 + 32*m_n)  e_mode = 3'd3;
        else if (m_rel < 12 + 32*m_n)  e_mode = 3'd4;
        else                           e_mode = 3'd0;
        abort = (e_mode != 3'd0) && (blank == 0);
        do_latch = m_busy && !abort && (m_rel == 9 + 32*m_n) &&
                   ((m_n == 0) || ((req != '0) && (m_n < MAXP) && (blank >= 35 + MARGIN)));
        e_ack = '0;
        win = -1;
        if (do_latch) begin
            for (int k = 0; k < N; k++)
                if (win < 0 && req[(m_rr + k) % N]) win = (m_rr + k) % N;
            if (win >= 0) e_ack[win] = 1'b1;
        end
        exp_v = {e_mode, (e_mode == 3'd3), m_ovr, e_ack, m_hdr, m_sub};
        pop = obs_ack;

        m_ovr = abort;
        if (!m_busy) begin
            if ((req != '0) && (blank >= 45 + MARGIN)) begin
                m_busy = 1'b1; m_rel = 0; m_n = 0;
            end
        end else if (abort) begin
            m_busy = 1'b0;
        end else begin
            if (do_latch) begin
                if (win >= 0) begin
                    m_hdr = cur_hdr[win];
                    m_sub = cur_sub[win];
                    m_rr  = (win + 1) % N;
                end else begin
                    m_hdr = '0;
                    m_sub = '0;
                end
                m_n++;
            end
            m_rel++;
            if (m_rel == 12 + 32*m_n + CD) m_busy = 1'b0;
        end
        if (blank_dec && blank_val > 0) blank_val--;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obs_v !== 257'd0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got=%h exp=0", cyc, obs_v);
            end
        end
    endtask

    task automatic test_single();
        int n_pre = 0, n_lead = 0, n_dip = 0, n_trail = 0, n_ack = 0;
        logic [N-1:0] first_ack = '0;
        do_reset();
        want[0] = 1;
        blank_val = 200;
        for (int c = 0; c < 70; c++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (obs_mode == 3'd1) n_pre++;
            if (obs_mode == 3'd2) n_lead++;
            if (obs_dip) n_dip++;
            if (obs_mode == 3'd4) n_trail++;
            if (obs_ack != '0) begin n_ack++; if (n_ack == 1) first_ack = obs_ack; end
        end
        checks++;
        if (n_pre != 8 || n_lead != 2 || n_dip != 32 || n_trail != 2) begin
            failures++;
            $display("FAIL single_lengths got pre=%0d lead=%0d dip=%0d trail=%0d exp 8/2/32/2",
                     n_pre, n_lead, n_dip, n_trail);
        end
        checks++;
        if (n_ack != 1 || first_ack !== 4'b0001) begin
            failures++;
            $display("FAIL single_ack got n=%0d ack=%b exp n=1 ack=0001", n_ack, first_ack);
        end
    endtask

    task automatic test_back_to_back();
        int acks[$];
        int n_dip = 0, bad = 0;
        bit seen_trail = 1'b0;
        do_reset();
        for (int i = 0; i < N; i++) want[i] = 1000000;
        blank_val = 1000;
        for (int c = 0; c < 640; c++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (obs_mode == 3'd4) seen_trail = 1'b1;
            if (!seen_trail) begin
                if (obs_dip) n_dip++;
                for (int i = 0; i < N; i++) if (obs_ack[i]) acks.push_back(i);
            end
        end
        for (int k = 0; k < acks.size(); k++) if (acks[k] != k % N) bad++;
        checks++;
        if (acks.size() != MAXP || bad != 0 || n_dip != 32*MAXP) begin
            failures++;
            $display("FAIL back_to_back_order got acks=%0d misordered=%0d dip=%0d exp acks=18 misordered=0 dip=576",
                     acks.size(), bad, n_dip);
        end
    endtask

    task automatic test_threshold();
        int n_busy = 0, n_dip = 0, n_ack = 0;
        do_reset();
        want[1] = 2;
        blank_val = 48;
        for (int c = 0; c < 30; c++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL threshold48 cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (obs_mode != 3'd0) n_busy++;
        end
        checks++;
        if (n_busy != 0) begin
            failures++;
            $display("FAIL threshold48_idle got busy_cycles=%0d exp 0", n_busy);
        end
        blank_val = 49;
        blank_dec = 1'b1;
        for (int c = 0; c < 80; c++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL threshold49 cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (obs_dip) n_dip++;
            if (obs_ack != '0) n_ack++;
        end
        checks++;
        if (n_dip != 32 || n_ack != 1) begin
            failures++;
            $display("FAIL threshold49_single got dip=%0d acks=%0d exp dip=32 acks=1", n_dip, n_ack);
        end
    endtask

    task automatic test_abort();
        int zero_at = -1, n_ovr = 0;
        do_reset();
        want[2] = 1000000;
        blank_val = 1000;
        for (int c = 0; c < 60; c++) begin
            if (zero_at < 0 && m_busy && m_rel == 20) begin
                blank_val = 0;
                zero_at = cyc + 1;
            end
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL abort cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (obs_ovr) n_ovr++;
            if (zero_at >= 0 && cyc == zero_at + 1) begin
                checks++;
                if ({obs_mode, obs_dip, obs_ovr} !== {3'd0, 1'b0, 1'b1}) begin
                    failures++;
                    $display("FAIL abort_next got mode=%0d dip=%b ovr=%b exp mode=0 dip=0 ovr=1",
                             obs_mode, obs_dip, obs_ovr);
                end
            end
        end
        checks++;
        if (n_ovr != 1 || zero_at < 0) begin
            failures++;
            $display("FAIL abort_pulses got %0d exp 1", n_ovr);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] first_ack = '0;
        logic [256:0] snap;
        do_reset();
        want[1] = 1;
        blank_val = 1000;
        for (int c = 0; c < 25; c++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        snap = {bus.mode, bus.data_island_period, bus.overrun, bus.src_ack, bus.header,
                bus.sub_3, bus.sub_2, bus.sub_1, bus.sub_0};
        checks++;
        if (snap !== 257'd0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", snap);
        end
        do_reset();
        want[0] = 1;
        want[2] = 1;
        blank_val = 1000;
        for (int c = 0; c < 30; c++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (first_ack == '0 && obs_ack != '0) first_ack = obs_ack;
        end
        checks++;
        if (first_ack !== 4'b0001) begin
            failures++;
            $display("FAIL reset_rr got ack=%b exp 0001", first_ack);
        end
    endtask

    task automatic test_random();
        int len, cut;
        do_reset();
        rnd_arrive = 1'b1;
        for (int seg = 0; seg < 8; seg++) begin
            blank_val = int'($urandom_range(20, 420));
            blank_dec = 1'b1;
            len = blank_val + int'($urandom_range(5, 30));
            cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, blank_val - 1)) : -1;
            for (int t = 0; t < len; t++) begin
                if (t == cut) blank_val = 0;
                tick();
                checks++;
                if (obs_v !== exp_v) begin
                    failures++;
                    $display("FAIL random seg=%0d cyc=%0d got=%h exp=%h", seg, cyc, obs_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_threshold();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
